// File: rtl/sobel_window_gen_pkg.sv
// sobel_window_gen_pkg: pixel type and 3x3 window indices shared with sobelfilter
package sobel_window_gen_pkg;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
  localparam int W_TL = 0;
  localparam int W_T  = 1;
  localparam int W_TR = 2;
  localparam int W_L  = 3;
  localparam int W_C  = 4;
  localparam int W_R  = 5;
  localparam int W_BL = 6;
  localparam int W_B  = 7;
  localparam int W_BR = 8;
endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// line_buffer: one-line pixel store, combinational read of old data, write on clk
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign dout = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 neighbourhoods for sobelfilter
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = sobel_window_gen_pkg::PIX_W,
  parameter int COL_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] w0,
  output logic [PIX_W-1:0] w1,
  output logic [PIX_W-1:0] w2,
  output logic [PIX_W-1:0] w3,
  output logic [PIX_W-1:0] w4,
  output logic [PIX_W-1:0] w5,
  output logic [PIX_W-1:0] w6,
  output logic [PIX_W-1:0] w7,
  output logic [PIX_W-1:0] w8,
  output logic             win_valid
);
  localparam int AW = $clog2(IMG_WIDTH);
  logic [COL_W-1:0] col, cur;
  logic [1:0]       row_cnt;
  logic [PIX_W-1:0] win [9];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic             last_col;
  // a refresh with a pixel makes that pixel column 0 of the new frame
  assign cur      = refresh ? '0 : col;
  assign last_col = cur == COL_W'(IMG_WIDTH - 1);
  // both lines in one word: row r-1 ages into row r-2 as the new pixel lands
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(2 * PIX_W), .AW(AW)) u_lb (
    .clk  (clk),
    .addr (cur[AW-1:0]),
    .we   (pix_valid),
    .din  ({lb1_q, pix_in}),
    .dout ({lb0_q, lb1_q})
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col       <= '0;
      row_cnt   <= '0;
      win_valid <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      win_valid <= pix_valid && !refresh && row_cnt == 2'd2 && col >= COL_W'(2);
      if (pix_valid) begin
        col       <= last_col ? '0 : cur + 1'b1;
        row_cnt   <= refresh ? '0 : (last_col && row_cnt != 2'd2) ? row_cnt + 2'd1 : row_cnt;
        win[W_TL] <= win[W_T];
        win[W_T]  <= win[W_TR];
        win[W_TR] <= lb0_q;
        win[W_L]  <= win[W_C];
        win[W_C]  <= win[W_R];
        win[W_R]  <= lb1_q;
        win[W_BL] <= win[W_B];
        win[W_B]  <= win[W_BR];
        win[W_BR] <= pix_in;
      end else if (refresh) begin
        col     <= '0;
        row_cnt <= '0;
      end
    end
  assign w0 = win[W_TL];
  assign w1 = win[W_T];
  assign w2 = win[W_TR];
  assign w3 = win[W_L];
  assign w4 = win[W_C];
  assign w5 = win[W_R];
  assign w6 = win[W_BL];
  assign w7 = win[W_B];
  assign w8 = win[W_BR];
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: image-array reference model checks of sobel_window_gen on a 4-wide image
module tb_sobel_window_gen;
  logic       clk, rst, refresh, pix_valid, win_valid;
  logic [7:0] pix_in, w0, w1, w2, w3, w4, w5, w6, w7, w8;
  int         n_vec, n_err, pulses, mr, mc;
  logic [7:0] img [3][4];
  logic [7:0] last_p;

  sobel_window_gen #(.IMG_WIDTH(4), .PIX_W(8), .COL_W(2)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .pix_in(pix_in), .pix_valid(pix_valid),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .win_valid(win_valid)
  );

  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic rf, input logic [7:0] p);
    logic       ev;
    logic [7:0] ew [9];
    logic [7:0] ow [9];
    pix_valid = v;
    refresh   = rf;
    pix_in    = p;
    ev        = 1'b0;
    for (int i = 0; i < 9; i++) ew[i] = 8'h0;
    if (rf) begin
      mr = 0;
      mc = 0;
    end
    if (v) begin
      img[mr % 3][mc] = p;
      last_p = p;
      if (mr >= 2 && mc >= 2) begin
        ev = 1'b1;
        for (int i = 0; i < 9; i++) ew[i] = img[(mr - 2 + i / 3) % 3][mc - 2 + i % 3];
      end
      mc++;
      if (mc == 4) begin
        mc = 0;
        mr++;
      end
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    refresh   = 1'b0;
    chk("win_valid", {31'b0, win_valid}, {31'b0, ev});
    chk("w8_newest", {24'b0, w8}, {24'b0, last_p});
    if (win_valid) pulses++;
    if (ev) begin
      ow = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};
      for (int i = 0; i < 9; i++) chk($sformatf("window_w%0d", i), {24'b0, ow[i]}, {24'b0, ew[i]});
    end
  endtask

  task automatic frame(input int base, input bit gap);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 8'(base + k));
      if (gap) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; pulses = 0; mr = 0; mc = 0; last_p = 8'h0;
    rst = 0; refresh = 0; pix_valid = 0; pix_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_win_valid", {31'b0, win_valid}, 32'd0);
    chk("reset_window", {w0, w1, w2, w3} | {w4, w5, w6, w7} | {24'b0, w8}, 32'd0);
    rst = 1;

    frame(0, 1'b0);
    chk("pulses_cont", pulses, 4);
    chk("last_w0", {24'b0, w0}, 32'd5);
    chk("last_w4", {24'b0, w4}, 32'd10);
    chk("last_w8", {24'b0, w8}, 32'd15);

    step(1'b0, 1'b1, 8'h0);
    pulses = 0;
    frame(0, 1'b1);
    chk("pulses_gap", pulses, 4);

    step(1'b0, 1'b1, 8'h0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 8'(k));
    step(1'b0, 1'b1, 8'h0);
    pulses = 0;
    frame(100, 1'b0);
    chk("pulses_refresh", pulses, 4);

    step(1'b0, 1'b1, 8'h0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 8'(k));
    pulses = 0;
    step(1'b1, 1'b1, 8'd100);
    for (int k = 1; k < 16; k++) step(1'b1, 1'b0, 8'(100 + k));
    chk("pulses_refresh_pix", pulses, 4);

    step(1'b0, 1'b1, 8'h0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(k));
    #5;
    rst = 0;
    #1;
    chk("async_win_valid", {31'b0, win_valid}, 32'd0);
    chk("async_window", {w0, w1, w2, w3} | {w4, w5, w6, w7} | {24'b0, w8}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    mr = 0; mc = 0; last_p = 8'h0;
    pulses = 0;
    frame(0, 1'b0);
    chk("pulses_after_rst", pulses, 4);

    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
